// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the round-robin 2:1 mux arbiter.
//   arb_state_t : arbiter FSM state encoding
//   OWNER_A/B   : owner encoding, identical to the mux select (1 = a, 0 = b)
package mux_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2
    } arb_state_t;

    localparam logic OWNER_A = 1'b1;
    localparam logic OWNER_B = 1'b0;

endpackage

// File: rtl/mux2_rr_arbiter_mux.sv
// Team 2:1 single-bit mux datapath, purely combinational.
//   sel : select, 1 = a, 0 = b
//   a   : leg selected when sel = 1
//   b   : leg selected when sel = 0
//   y   : selected data
module mux2_rr_arbiter_mux (
    input  logic sel,
    input  logic a,
    input  logic b,
    output logic y
);

    assign y = sel ? a : b;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter sharing a 2:1 single-bit mux between requesters A and B.
// One owner at a time, ownership capped at MAX_HOLD cycles while the other side
// waits, and the muxed data registered as a clean out/out_neg pair.
//   clk, rst_n     : clock (rising edge), asynchronous active-low reset
//   req_a, req_b   : level requests
//   a, b           : requester data
//   gnt_a, gnt_b   : registered grants, never both high
//   sel            : registered mux select (1 = a, 0 = b)
//   busy           : either grant active
//   out, out_neg   : registered mux result and its complement
module mux2_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int unsigned MAX_HOLD = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_a,
    input  logic req_b,
    input  logic a,
    input  logic b,
    output logic gnt_a,
    output logic gnt_b,
    output logic sel,
    output logic busy,
    output logic out,
    output logic out_neg
);

    localparam int unsigned CNT_W = $clog2(MAX_HOLD);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_owner_q;
    logic             gnt_a_q, gnt_b_q, sel_q;
    logic             out_q, out_neg_q;
    logic             take_a, take_b;
    logic             mux_y;

    // Next-state decision. take_a/take_b flag a fresh grant entry, which
    // clears the hold counter and updates sel and last_owner.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        take_a  = 1'b0;
        take_b  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_a && req_b) begin
                    // Tie goes to whoever did not own the mux last.
                    if (last_owner_q == OWNER_B) take_a = 1'b1;
                    else                         take_b = 1'b1;
                end else if (req_a) begin
                    take_a = 1'b1;
                end else if (req_b) begin
                    take_b = 1'b1;
                end
            end
            OWN_A: begin
                if (!req_a) begin
                    if (req_b) take_b = 1'b1;
                    else       state_d = IDLE;
                end else if (req_b && cnt_q == HOLD_LAST) begin
                    take_b = 1'b1;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OWN_B: begin
                if (!req_b) begin
                    if (req_a) take_a = 1'b1;
                    else       state_d = IDLE;
                end else if (req_a && cnt_q == HOLD_LAST) begin
                    take_a = 1'b1;
                end else if (cnt_q != HOLD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (take_a) begin
            state_d = OWN_A;
            cnt_d   = '0;
        end else if (take_b) begin
            state_d = OWN_B;
            cnt_d   = '0;
        end
    end

    // Datapath: the mux is fed by the registered select only.
    mux2_rr_arbiter_mux u_mux (
        .sel (sel_q),
        .a   (a),
        .b   (b),
        .y   (mux_y)
    );

    // FSM state and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_owner_q <= OWNER_B;
            gnt_a_q      <= 1'b0;
            gnt_b_q      <= 1'b0;
            sel_q        <= 1'b0;
            out_q        <= 1'b0;
            out_neg_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gnt_a_q <= (state_d == OWN_A);
            gnt_b_q <= (state_d == OWN_B);
            // sel holds through IDLE; it only moves on a grant entry.
            if (take_a) begin
                sel_q        <= OWNER_A;
                last_owner_q <= OWNER_A;
            end else if (take_b) begin
                sel_q        <= OWNER_B;
                last_owner_q <= OWNER_B;
            end
            out_q     <= mux_y;
            out_neg_q <= ~mux_y;
        end
    end

    assign gnt_a   = gnt_a_q;
    assign gnt_b   = gnt_b_q;
    assign sel     = sel_q;
    assign busy    = gnt_a_q | gnt_b_q;
    assign out     = out_q;
    assign out_neg = out_neg_q;

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter (MAX_HOLD = 4).
// Vector encoding: {req_a, req_b, a, b, exp_gnt_a, exp_gnt_b, exp_sel, exp_out};
// inputs are driven for one cycle, expectations apply to the cycle that follows.
module tb_mux2_rr_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic req_a = 1'b0, req_b = 1'b0, a = 1'b0, b = 1'b0;
    logic gnt_a, gnt_b, sel, busy, out, out_neg;

    always #5 clk = ~clk;

    mux2_rr_arbiter #(.MAX_HOLD(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req_a   (req_a),
        .req_b   (req_b),
        .a       (a),
        .b       (b),
        .gnt_a   (gnt_a),
        .gnt_b   (gnt_b),
        .sel     (sel),
        .busy    (busy),
        .out     (out),
        .out_neg (out_neg)
    );

    typedef struct {
        int   due;
        int   tid;
        int   row;
        logic ga;
        logic gb;
        logic sl;
        logic o;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int tid, input int row,
                       input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s t%0d r%0d: got %b, expected %b", name, tid, row, act, exp);
        end
    endtask

    // Monitor: compares the oldest expectation once its cycle arrives.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            if (q[0].due < cyc) begin
                e = q.pop_front();
                n_vec++;
                n_bad++;
                $display("FAIL missed t%0d r%0d: due %0d, now %0d", e.tid, e.row, e.due, cyc);
            end else if (q[0].due == cyc) begin
                e = q.pop_front();
                chk("gnt_a",   e.tid, e.row, gnt_a,   e.ga);
                chk("gnt_b",   e.tid, e.row, gnt_b,   e.gb);
                chk("sel",     e.tid, e.row, sel,     e.sl);
                chk("busy",    e.tid, e.row, busy,    e.ga | e.gb);
                chk("out",     e.tid, e.row, out,     e.o);
                chk("out_neg", e.tid, e.row, out_neg, ~e.o);
            end
        end
    end

    task automatic apply_v(input int tid, input int row, input logic [7:0] v);
        @(posedge clk);
        #1;
        req_a = v[7];
        req_b = v[6];
        a     = v[5];
        b     = v[4];
        q.push_back('{due: cyc + 1, tid: tid, row: row, ga: v[3], gb: v[2], sl: v[1], o: v[0]});
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (q.size() > 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
            q.delete();
        end
    endtask

    task automatic chk_reset_state(input int tid, input int row);
        chk("rst_gnt_a",   tid, row, gnt_a,   1'b0);
        chk("rst_gnt_b",   tid, row, gnt_b,   1'b0);
        chk("rst_sel",     tid, row, sel,     1'b0);
        chk("rst_busy",    tid, row, busy,    1'b0);
        chk("rst_out",     tid, row, out,     1'b0);
        chk("rst_out_neg", tid, row, out_neg, 1'b1);
    endtask

    task automatic reset_dut();
        drain();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        req_a = 1'b0;
        req_b = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_reset_state(0, 0);
    endtask

    logic [7:0] t_mid  [2];
    logic [7:0] t_rr   [23];
    logic [7:0] t_one  [5];
    logic [7:0] t_sat  [13];

    initial begin
        // A owns, then reset lands between clock edges.
        t_mid = '{8'b1010_1010, 8'b1010_1011};
        // Tie from reset, round robin, early release, idle hold, later ties.
        t_rr = '{8'b1110_1010, 8'b1110_1011, 8'b1110_1011, 8'b1110_1011,
                 8'b1110_0101, 8'b1110_0100, 8'b1110_0100, 8'b1110_0100,
                 8'b1110_1010, 8'b1110_1011, 8'b0110_0101, 8'b0110_0100,
                 8'b1010_1010, 8'b0010_0011, 8'b0110_0101, 8'b0011_0001,
                 8'b0010_0000, 8'b0001_0001, 8'b0010_0000, 8'b1110_1010,
                 8'b0000_0010, 8'b1110_0101, 8'b0000_0000};
        // Single requester A with a toggling 1,0,1.
        t_one = '{8'b1010_1010, 8'b1010_1011, 8'b1000_1010, 8'b1010_1011,
                  8'b0000_0010};
        // A alone for 10 cycles, then B arrives after the counter saturated.
        t_sat = '{8'b1010_1010, 8'b1010_1011, 8'b1010_1011, 8'b1010_1011,
                  8'b1010_1011, 8'b1010_1011, 8'b1010_1011, 8'b1010_1011,
                  8'b1010_1011, 8'b1010_1011, 8'b1110_0101, 8'b1110_0100,
                  8'b0000_0000};

        reset_dut();

        for (int i = 0; i < 2; i++) apply_v(1, i, t_mid[i]);
        drain();
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_state(1, 99);

        reset_dut();
        for (int i = 0; i < 23; i++) apply_v(2, i, t_rr[i]);

        reset_dut();
        for (int i = 0; i < 5; i++) apply_v(3, i, t_one[i]);

        reset_dut();
        for (int i = 0; i < 13; i++) apply_v(4, i, t_sat[i]);

        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
